// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared definitions for the program-flow controller.
//   Contents : sequencer state enum, HALT instruction encoding, default PC width.
//   Users    : pc_sequencer, the Control block and the testbench.
package pc_seq_pkg;

   localparam int unsigned PC_WIDTH_DEF = 11;
   localparam logic [8:0]  HALT_INST    = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2,
      DONE  = 2'd3
   } pc_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-flow controller for the 9-bit-instruction core.
//   Owns the program counter and the start/done handshake, applies branch
//   targets, inserts a stall cycle for loads, and detects HALT / end of ROM.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   start         in   level, sampled only in IDLE/DONE
//   inst          in   current instruction from instr_ROM
//   branch_en     in   taken branch for the current instruction
//   branch_target in   branch target address
//   mem_read_en   in   current instruction is a data_mem load
//   pc            out  instruction address
//   commit_en     out  current instruction retires this cycle (combinational)
//   busy          out  sequencer is in RUN or STALL
//   done          out  program finished; held until next start
//   overflow      out  finished by running off the end of ROM
//   timeout       out  finished by the retired-instruction watchdog
//
// Build option
//   PC_SEQ_WATCHDOG_EN : adds a 16-bit retired-instruction counter and the
//   WDOG_LIMIT parameter; without it timeout stays 0.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned         PC_WIDTH   = PC_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0] START_ADDR = '0,
   parameter bit                  LOAD_STALL = 1'b1
`ifdef PC_SEQ_WATCHDOG_EN
   ,
   parameter logic [15:0]         WDOG_LIMIT = 16'hFFFF
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [8:0]          inst,
   input  logic                branch_en,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                mem_read_en,
   output logic [PC_WIDTH-1:0] pc,
   output logic                commit_en,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic                timeout
);

   pc_state_e           state_q;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                busy_q, done_q, ovf_q, tmo_q;
   logic                launch, is_halt, stall_req, at_end;
   logic                rom_end, wdog_hit, finish;

   assign launch    = ((state_q == IDLE) || (state_q == DONE)) && start;
   assign is_halt   = (inst == HALT_INST);
   assign stall_req = LOAD_STALL && mem_read_en;
   assign at_end    = (pc_q == '1);

   // HALT never retires; a load retires in its STALL cycle, not in RUN.
   assign commit_en = (state_q == STALL) ||
                      ((state_q == RUN) && !is_halt && !stall_req);

   // Falling off the last address ends the program instead of wrapping.
   assign rom_end = commit_en && !branch_en && at_end;

`ifdef PC_SEQ_WATCHDOG_EN
   logic [15:0] wcnt_q;

   assign wdog_hit = commit_en && ((wcnt_q + 16'd1) == WDOG_LIMIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wcnt_q <= '0;
      end else if (launch) begin
         wcnt_q <= '0;
      end else if (commit_en) begin
         wcnt_q <= wcnt_q + 16'd1;
      end
   end
`else
   assign wdog_hit = 1'b0;
`endif

   assign finish = rom_end || wdog_hit;

   always_comb begin
      pc_d = pc_q;
      if (launch) begin
         pc_d = START_ADDR;
      end else if (commit_en) begin
         if (branch_en) begin
            pc_d = branch_target;
         end else if (!at_end) begin
            pc_d = pc_q + PC_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= START_ADDR;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         pc_q <= pc_d;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  ovf_q   <= 1'b0;
                  tmo_q   <= 1'b0;
               end
            end
            RUN: begin
               if (is_halt) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (stall_req) begin
                  state_q <= STALL;
               end else if (finish) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  ovf_q   <= rom_end;
                  tmo_q   <= wdog_hit;
               end
            end
            STALL: begin
               if (finish) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  ovf_q   <= rom_end;
                  tmo_q   <= wdog_hit;
               end else begin
                  state_q <= RUN;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pc       = pc_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign timeout  = tmo_q;

endmodule
